// File: rtl/pattern_game_pkg.sv
// pattern_game_pkg: shared state encoding, switch IDs and game depth for the pattern game and its autoplayer
package pattern_game_pkg;
    localparam int GAME_LIMIT_DEF = 10;
    typedef enum logic [2:0] {ST_IDLE, ST_LISTEN, ST_PRESS, ST_GAP, ST_ERROR} state_t;
    localparam logic [1:0] SW_1 = 2'd0;
    localparam logic [1:0] SW_2 = 2'd1;
    localparam logic [1:0] SW_3 = 2'd2;
    localparam logic [1:0] SW_4 = 2'd3;
    function automatic logic [1:0] led_to_id(input logic [3:0] r);
        return r[3] ? SW_4 : r[2] ? SW_3 : r[1] ? SW_2 : SW_1;
    endfunction
endpackage

// File: rtl/pattern_game_autoplayer_capture_buf.sv
// pattern_capture_buf: small 2-bit register file holding captured switch IDs
module pattern_capture_buf #(
    parameter int DEPTH = 11,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [1:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [1:0]    o_rdata
);
    logic [1:0] mem [DEPTH];
    // synchronous write, cleared asynchronously on reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end
    assign o_rdata = mem[i_raddr];
endmodule

// File: rtl/pattern_game_autoplayer.sv
// pattern_game_autoplayer: records game LED patterns and replays them as timed switch presses (optional AUTOPLAYER_MISTAKE_EN)
module pattern_game_autoplayer
    import pattern_game_pkg::*;
#(
    parameter int GAME_LIMIT = GAME_LIMIT_DEF,
    parameter int IDLE_CLKS  = 12500000,
    parameter int PRESS_CLKS = 500000,
    parameter int GAP_CLKS   = 500000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
`ifdef AUTOPLAYER_MISTAKE_EN
    input  logic [3:0] i_fail_round,
`endif
    input  logic       i_led_1,
    input  logic       i_led_2,
    input  logic       i_led_3,
    input  logic       i_led_4,
    output logic       o_switch_1,
    output logic       o_switch_2,
    output logic       o_switch_3,
    output logic       o_switch_4,
    output logic       o_busy,
    output logic       o_error,
    output logic [3:0] o_count
);
    localparam int DEPTH = GAME_LIMIT + 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int TMAX  = (IDLE_CLKS > PRESS_CLKS) ? ((IDLE_CLKS > GAP_CLKS) ? IDLE_CLKS : GAP_CLKS)
                                                    : ((PRESS_CLKS > GAP_CLKS) ? PRESS_CLKS : GAP_CLKS);
    localparam int TW    = $clog2(TMAX) + 1;

    state_t        state, state_d;
    logic [3:0]    led, r_led, rise, sw, sw_d;
    logic [3:0]    count, count_d, index, index_d;
    logic [TW-1:0] timer, timer_d;
    logic          we, fail_hit;
    logic [1:0]    rd_id, play_id;

    assign led  = {i_led_4, i_led_3, i_led_2, i_led_1};
    assign rise = led & ~r_led;

    pattern_capture_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (we),
        .i_waddr (count[AW-1:0]),
        .i_wdata (led_to_id(rise)),
        .i_raddr (index_d[AW-1:0]),
        .o_rdata (rd_id)
    );

    // next state, capture control and replay sequencing; enable low overrides everything
    always_comb begin
        state_d = state;
        count_d = count;
        index_d = index;
        timer_d = timer;
        we      = 1'b0;
        case (state)
            ST_IDLE: begin
                count_d = '0;
                index_d = '0;
                timer_d = '0;
                if (i_enable) state_d = ST_LISTEN;
            end
            ST_LISTEN: begin
                if (rise != 4'b0 && (!$onehot(rise) || (led & ~rise) != 4'b0 || count == 4'(DEPTH))) begin
                    state_d = ST_ERROR;
                end else begin
                    if (rise != 4'b0) begin
                        we      = 1'b1;
                        count_d = count + 4'd1;
                    end
                    if (led != 4'b0 || count == 4'd0) timer_d = '0;
                    else if (timer == TW'(IDLE_CLKS - 1)) begin
                        state_d = ST_PRESS;
                        index_d = '0;
                    end else timer_d = timer + 1'b1;
                end
            end
            ST_PRESS: begin
                if (timer == TW'(PRESS_CLKS - 1)) state_d = ST_GAP;
                else timer_d = timer + 1'b1;
            end
            ST_GAP: begin
                if (timer == TW'(GAP_CLKS - 1)) begin
                    if (index + 4'd1 == count) begin
                        state_d = ST_LISTEN;
                        count_d = '0;
                    end else begin
                        state_d = ST_PRESS;
                        index_d = index + 4'd1;
                    end
                end else timer_d = timer + 1'b1;
            end
            ST_ERROR: state_d = ST_ERROR;
            default: state_d = ST_IDLE;
        endcase
        if (!i_enable) begin
            state_d = ST_IDLE;
            count_d = '0;
            index_d = '0;
            we      = 1'b0;
        end
        if (state_d != state) timer_d = '0;
    end

`ifdef AUTOPLAYER_MISTAKE_EN
    assign fail_hit = ({1'b0, count_d} == {1'b0, i_fail_round} + 5'd1) && (index_d + 4'd1 == count_d);
`else
    assign fail_hit = 1'b0;
`endif
    assign play_id = rd_id + {1'b0, fail_hit};
    assign sw_d    = (state_d == ST_PRESS) ? (4'b0001 << play_id) : 4'b0000;

    // state, counters, LED history and registered switch drive
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
            count <= '0;
            index <= '0;
            timer <= '0;
            r_led <= '0;
            sw    <= '0;
        end else begin
            state <= state_d;
            count <= count_d;
            index <= index_d;
            timer <= timer_d;
            r_led <= led;
            sw    <= sw_d;
        end
    end

    assign {o_switch_4, o_switch_3, o_switch_2, o_switch_1} = sw;
    assign o_busy  = (state == ST_PRESS) || (state == ST_GAP);
    assign o_error = (state == ST_ERROR);
    assign o_count = count;
endmodule

// File: tb/tb_pattern_game_autoplayer.sv
// tb_pattern_game_autoplayer: directed checks of capture, replay, error, abort and optional mistake injection
module tb_pattern_game_autoplayer;
    logic       clk = 1'b0;
    logic       rst_n, enable;
    logic [3:0] leds;
    logic [3:0] sw;
    logic       busy, error;
    logic [3:0] count;
    int         vectors = 0;
    int         miscompares = 0;
`ifdef AUTOPLAYER_MISTAKE_EN
    logic [3:0] fail_round = 4'hF;
`endif

    always #5 clk = ~clk;

    pattern_game_autoplayer #(.GAME_LIMIT(10), .IDLE_CLKS(20), .PRESS_CLKS(5), .GAP_CLKS(5)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_enable     (enable),
`ifdef AUTOPLAYER_MISTAKE_EN
        .i_fail_round (fail_round),
`endif
        .i_led_1      (leds[0]),
        .i_led_2      (leds[1]),
        .i_led_3      (leds[2]),
        .i_led_4      (leds[3]),
        .o_switch_1   (sw[0]),
        .o_switch_2   (sw[1]),
        .o_switch_3   (sw[2]),
        .o_switch_4   (sw[3]),
        .o_busy       (busy),
        .o_error      (error),
        .o_count      (count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [3:0] m, input int on, input int off);
        leds = m;
        repeat (on) step();
        leds = 4'b0;
        repeat (off) step();
    endtask

    task automatic wait_sw(input logic [3:0] m, input string tag);
        int n = 0;
        while (sw !== m && n < 60) begin
            step();
            n++;
        end
        chk(tag, {28'b0, sw}, {28'b0, m});
    endtask

    task automatic replay_check(input logic [3:0] m, input string tag);
        for (int i = 0; i < 5; i++) begin
            chk({tag, "_press"}, {27'b0, busy, sw}, {27'b0, 1'b1, m});
            step();
        end
        for (int i = 0; i < 5; i++) begin
            chk({tag, "_gap"}, {27'b0, busy, sw}, {27'b0, 1'b1, 4'b0});
            step();
        end
    endtask

    task automatic recover();
        enable = 1'b0;
        leds = 4'b0;
        step();
        chk("recover_idle", {26'b0, error, busy, count}, 32'b0);
        enable = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        leds = 4'b0;
        repeat (2) step();
        chk("reset_outputs", {25'b0, sw, busy, error, count}, 32'b0);
        rst_n = 1'b1;
        enable = 1'b1;
        step();

        // single entry on LED 3
        pulse(4'b0100, 4, 0);
        chk("single_count", {28'b0, count}, 32'd1);
        wait_sw(4'b0100, "single_start");
        replay_check(4'b0100, "single");
        chk("single_done", {26'b0, busy, error, count}, 32'b0);
        chk("single_sw_off", {28'b0, sw}, 32'b0);

        // three entries: LEDs 1, 4, 2
        pulse(4'b0001, 3, 3);
        pulse(4'b1000, 3, 3);
        pulse(4'b0010, 3, 0);
        chk("three_count", {28'b0, count}, 32'd3);
        wait_sw(4'b0001, "three_start");
        replay_check(4'b0001, "three_e0");
        replay_check(4'b1000, "three_e1");
        replay_check(4'b0010, "three_e2");
        chk("three_done", {27'b0, busy, count}, 32'b0);

        // two simultaneous rises
        leds = 4'b0011;
        step();
        chk("collision_err", {27'b0, error, sw}, {27'b0, 1'b1, 4'b0});
        leds = 4'b0;
        step();
        chk("collision_stays", {31'b0, error}, 32'd1);
        recover();

        // rise while another LED is already lit
        leds = 4'b0001;
        step();
        chk("lit_first_ok", {27'b0, error, count}, 32'd1);
        leds = 4'b0011;
        step();
        chk("lit_rise_err", {31'b0, error}, 32'd1);
        recover();

        // overflow on the 12th rise
        for (int i = 0; i < 11; i++) pulse(4'b0001, 1, 1);
        chk("ovf_count11", {27'b0, error, count}, 32'd11);
        leds = 4'b0001;
        step();
        chk("ovf_err", {31'b0, error}, 32'd1);
        recover();

        // abort mid-press
        pulse(4'b1000, 2, 0);
        wait_sw(4'b1000, "abort_start");
        step();
        step();
        chk("abort_holding", {27'b0, busy, sw}, {27'b0, 1'b1, 4'b1000});
        enable = 1'b0;
        step();
        chk("abort_release", {23'b0, busy, error, sw, count}, 32'b0);
        enable = 1'b1;
        step();

`ifdef AUTOPLAYER_MISTAKE_EN
        // deliberate mistake on last entry of a 2-entry round
        fail_round = 4'd1;
        pulse(4'b0010, 3, 3);
        pulse(4'b1000, 3, 0);
        chk("mistake_count", {28'b0, count}, 32'd2);
        wait_sw(4'b0010, "mistake_start");
        replay_check(4'b0010, "mistake_e0");
        replay_check(4'b0001, "mistake_e1");
        chk("mistake_done", {27'b0, busy, count}, 32'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
